flush_queue: RTL and testbench
==============================

FLUSH_QUEUE -- requirements
Module: flush_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 97: entry width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: entry count; legal values are powers of 2, >= 2.
REQ-003 The block SHALL have parameter AFULL_TH, default 3: almost-full threshold; legal range 1..DEPTH.
REQ-004 The block SHALL have parameter CNT_WIDTH, default $clog2(DEPTH+1): occupancy counter width.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port sync_q_wen, input, 1 bit: write request.
REQ-008 The block SHALL have port sync_q_wdata, input, WIDTH bits: write data.
REQ-009 The block SHALL have port sync_q_wok, output, 1 bit: not full; a write is accepted.
REQ-010 The block SHALL have port sync_q_ren, input, 1 bit: read (pop) request.
REQ-011 The block SHALL have port sync_q_rdata, output, WIDTH bits: head entry, first-word-fall-through.
REQ-012 The block SHALL have port sync_q_rok, output, 1 bit: not empty; the head entry is valid.
REQ-013 The block SHALL have port sync_q_flush, input, 1 bit: synchronous discard of all entries.
REQ-014 The block SHALL have port sync_q_count, output, CNT_WIDTH bits: current occupancy.
REQ-015 The block SHALL have port sync_q_afull, output, 1 bit: occupancy >= AFULL_TH.
REQ-016 The block SHALL have port sync_q_ovf, output, 1 bit: sticky flag; a write was attempted while full.
REQ-017 The block SHALL have port sync_q_udf, output, 1 bit: sticky flag; a read was attempted while empty.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 Outputs sync_q_wok, sync_q_rok and sync_q_afull SHALL be decoded from the registered count only: wok = (count != DEPTH), rok = (count != 0), afull = (count >= AFULL_TH).
REQ-020 A write SHALL be accepted iff sync_q_wen=1, sync_q_wok=1 and sync_q_flush=0; sync_q_wdata is then stored at the write pointer and the write pointer advances by 1.
REQ-021 A read SHALL be accepted iff sync_q_ren=1, sync_q_rok=1 and sync_q_flush=0; the read pointer then advances by 1.
REQ-022 sync_q_rdata SHALL equal the entry at the read pointer whenever rok=1, with zero-cycle read latency (FWFT); its value when rok=0 is don't-care.
REQ-023 Write-to-read latency SHALL be 1 cycle; there is no combinational bypass, so a write into an empty queue sets rok on the next cycle.
REQ-024 Count update SHALL be +1 on write-only, -1 on read-only, and unchanged on simultaneous accepted write and read.
REQ-025 When full, a simultaneous wen and ren SHALL accept only the read, because wok=0.
REQ-026 When empty, a simultaneous wen and ren SHALL accept only the write, because rok=0.
REQ-027 Flush SHALL have highest priority: at the next edge both pointers and count go to 0, and any wen or ren in the same cycle is ignored.
REQ-028 sync_q_ovf SHALL set on any cycle with sync_q_wen=1, wok=0 and flush=0, and remain set until reset.
REQ-029 sync_q_udf SHALL set on any cycle with sync_q_ren=1, rok=0 and flush=0, and remain set until reset.
REQ-030 Flush SHALL NOT clear sync_q_ovf or sync_q_udf.
REQ-031 Entry contents SHALL NOT be cleared by flush or reset; only pointers, count and flags are reset.

Reset
REQ-032 While RST=1, the block SHALL asynchronously force pointers and count to 0, giving wok=1, rok=0, count=0, afull=0, ovf=0 and udf=0.
REQ-033 On RST release, the block SHALL accept traffic from the first rising CLK edge on which RST=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the queue behaves as freshly reset.

Verification
REQ-035 Verification SHALL cover, with WIDTH=8, DEPTH=4, AFULL_TH=3: write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; afull=1 from count 3; wok=0 at 4; then reads return 0x11,0x22,0x33,0x44 in order.
REQ-036 Verification SHALL cover: queue full with 0x11..0x44, then assert wen=1 (0x55) and ren=1 together -> 0x11 popped, 0x55 dropped, count=3, ovf=1; subsequent reads return 0x22,0x33,0x44.
REQ-037 Verification SHALL cover: empty queue, ren=1 and wen=1 (0xA5) together -> count=1, udf=1, rok=1 next cycle with rdata=0xA5.
REQ-038 Verification SHALL cover: 3 entries held, then flush=1 together with wen=1 (0x77) -> next cycle count=0, rok=0, wok=1, ovf and udf unchanged; the 0x77 write is not stored.
REQ-039 Verification SHALL cover wrap-around: 10 iterations of write followed by read with 2 entries resident -> pointers wrap and FIFO order is preserved.
REQ-040 Verification SHALL cover: RST pulsed asynchronously between clock edges with count=2 -> count=0, rok=0, ovf=0 and udf=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/flush_queue.sv
// flush_queue: synchronous FWFT circular-buffer queue with a synchronous flush,
// an occupancy count, an almost-full flag and sticky overflow/underflow flags.
module flush_queue #(
    parameter int unsigned WIDTH     = 97,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_TH  = 3,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 sync_q_wen,
    input  logic [WIDTH-1:0]     sync_q_wdata,
    output logic                 sync_q_wok,
    input  logic                 sync_q_ren,
    output logic [WIDTH-1:0]     sync_q_rdata,
    output logic                 sync_q_rok,
    input  logic                 sync_q_flush,
    output logic [CNT_WIDTH-1:0] sync_q_count,
    output logic                 sync_q_afull,
    output logic                 sync_q_ovf,
    output logic                 sync_q_udf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 wr_acc;
    logic                 rd_acc;

    // Accept decisions and next occupancy; flush overrides all traffic.
    always_comb begin
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        count_nxt = count;
        if (sync_q_flush) begin
            count_nxt = '0;
        end else begin
            wr_acc = sync_q_wen & sync_q_wok;
            rd_acc = sync_q_ren & sync_q_rok;
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count + CNT_WIDTH'(1);
                2'b01:   count_nxt = count - CNT_WIDTH'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Pointers, count, status flags (flags track the next count so they
    // always equal the decode of the registered count) and sticky errors.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sync_q_wok   <= 1'b1;
            sync_q_rok   <= 1'b0;
            sync_q_afull <= 1'b0;
            sync_q_ovf   <= 1'b0;
            sync_q_udf   <= 1'b0;
        end else begin
            if (sync_q_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (sync_q_wen && !sync_q_wok) begin
                    sync_q_ovf <= 1'b1;
                end
                if (sync_q_ren && !sync_q_rok) begin
                    sync_q_udf <= 1'b1;
                end
            end
            count        <= count_nxt;
            sync_q_wok   <= (count_nxt != CNT_WIDTH'(DEPTH));
            sync_q_rok   <= (count_nxt != '0);
            sync_q_afull <= (count_nxt >= CNT_WIDTH'(AFULL_TH));
        end
    end

    // Entry storage; contents survive flush and reset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= sync_q_wdata;
        end
    end

    assign sync_q_rdata = mem[rd_ptr];
    assign sync_q_count = count;

endmodule

// File: tb/tb_flush_queue.sv
// Directed self-checking bench for flush_queue (WIDTH=8, DEPTH=4, AFULL_TH=3).
module tb_flush_queue;

    logic       clk;
    logic       rst;
    logic       wen;
    logic [7:0] wdata;
    logic       wok;
    logic       ren;
    logic [7:0] rdata;
    logic       rok;
    logic       flush;
    logic [2:0] count;
    logic       afull;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    flush_queue #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AFULL_TH (3),
        .CNT_WIDTH(3)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .sync_q_wen   (wen),
        .sync_q_wdata (wdata),
        .sync_q_wok   (wok),
        .sync_q_ren   (ren),
        .sync_q_rdata (rdata),
        .sync_q_rok   (rok),
        .sync_q_flush (flush),
        .sync_q_count (count),
        .sync_q_afull (afull),
        .sync_q_ovf   (ovf),
        .sync_q_udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // status {wok,rok,afull,ovf,udf,count} while reset is held
        checks++;
        if ({wok, rok, afull, ovf, udf, count} !== {5'b10000, 3'd0}) begin
            errors++;
            $display("FAIL reset_status got %b exp %b", {wok, rok, afull, ovf, udf, count}, {5'b10000, 3'd0});
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1;
            wdata = vals[i];
            step();
            checks++;
            if ({count, afull, wok, rok} !== {3'(i + 1), (i >= 2), (i != 3), 1'b1}) begin
                errors++;
                $display("FAIL fill_%0d {count,afull,wok,rok} got %b exp %b", i,
                         {count, afull, wok, rok}, {3'(i + 1), (i >= 2), (i != 3), 1'b1});
            end
        end
        wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdata !== vals[i] || rok !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d rdata got %h rok %b exp %h rok 1", i, rdata, rok, vals[i]);
            end
            ren = 1'b1;
            step();
        end
        ren = 1'b0;
        checks++;
        if ({count, rok, wok, afull, ovf, udf} !== {3'd0, 5'b01000}) begin
            errors++;
            $display("FAIL drained_status got %b exp %b", {count, rok, wok, afull, ovf, udf}, {3'd0, 5'b01000});
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1;
            wdata = vals[i];
            step();
        end
        wdata = 8'h55;
        ren = 1'b1;
        checks++;
        if (rdata !== 8'h11 || wok !== 1'b0) begin
            errors++;
            $display("FAIL full_head rdata got %h wok %b exp 11 wok 0", rdata, wok);
        end
        step();
        wen = 1'b0;
        ren = 1'b0;
        checks++;
        if ({count, ovf, udf, wok} !== {3'd3, 3'b101}) begin
            errors++;
            $display("FAIL full_rw {count,ovf,udf,wok} got %b exp %b", {count, ovf, udf, wok}, {3'd3, 3'b101});
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rdata !== vals[i]) begin
                errors++;
                $display("FAIL full_rw_read_%0d got %h exp %h", i, rdata, vals[i]);
            end
            ren = 1'b1;
            step();
        end
        ren = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL full_rw_empty count got %0d exp 0", count);
        end
    endtask

    task automatic test_empty_rw();
        wen = 1'b1;
        ren = 1'b1;
        wdata = 8'hA5;
        step();
        wen = 1'b0;
        ren = 1'b0;
        checks++;
        if ({count, udf, rok, rdata} !== {3'd1, 2'b11, 8'hA5}) begin
            errors++;
            $display("FAIL empty_rw {count,udf,rok,rdata} got %h exp %h", {count, udf, rok, rdata}, {3'd1, 2'b11, 8'hA5});
        end
        ren = 1'b1;
        step();
        ren = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1;
            wdata = 8'h60 + 8'(i);
            step();
        end
        flush = 1'b1;
        wdata = 8'h77;
        step();
        flush = 1'b0;
        wen = 1'b0;
        checks++;
        if ({count, rok, wok, afull, ovf, udf} !== {3'd0, 5'b01011}) begin
            errors++;
            $display("FAIL flush_status got %b exp %b", {count, rok, wok, afull, ovf, udf}, {3'd0, 5'b01011});
        end
        wen = 1'b1;
        wdata = 8'h99;
        step();
        wen = 1'b0;
        checks++;
        if ({count, rdata} !== {3'd1, 8'h99}) begin
            errors++;
            $display("FAIL post_flush_write got %h exp %h", {count, rdata}, {3'd1, 8'h99});
        end
        ren = 1'b1;
        step();
        ren = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] model [$];
        logic [7:0] v;
        model = {};
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1;
            wdata = 8'hA0 + 8'(i);
            model.push_back(wdata);
            step();
        end
        wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wen = 1'b1;
            wdata = 8'hB0 + 8'(i);
            model.push_back(wdata);
            step();
            wen = 1'b0;
            v = model.pop_front();
            checks++;
            if (rdata !== v) begin
                errors++;
                $display("FAIL wrap_read_%0d got %h exp %h", i, rdata, v);
            end
            ren = 1'b1;
            step();
            ren = 1'b0;
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL wrap_count_%0d got %0d exp 2", i, count);
            end
        end
        while (model.size() > 0) begin
            v = model.pop_front();
            checks++;
            if (rdata !== v) begin
                errors++;
                $display("FAIL wrap_tail got %h exp %h", rdata, v);
            end
            ren = 1'b1;
            step();
            ren = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1;
            wdata = 8'hC0 + 8'(i);
            step();
        end
        wen = 1'b0;
        checks++;
        if ({count, ovf, udf} !== {3'd2, 2'b11}) begin
            errors++;
            $display("FAIL pre_reset got %b exp %b", {count, ovf, udf}, {3'd2, 2'b11});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({count, rok, wok, ovf, udf} !== {3'd0, 4'b0100}) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", {count, rok, wok, ovf, udf}, {3'd0, 4'b0100});
        end
        #1;
        rst = 1'b0;
        step();
        wen = 1'b1;
        wdata = 8'h5A;
        step();
        wen = 1'b0;
        checks++;
        if ({count, rok, rdata} !== {3'd1, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL after_reset got %h exp %h", {count, rok, rdata}, {3'd1, 1'b1, 8'h5A});
        end
    endtask

    initial begin
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        flush = 1'b0;
        wdata = 8'h00;
        #2;
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
